// File: rtl/stage_leaf_unpack.sv
// Leaf-record unpacker: buffers 3-field records in a small FIFO and streams each as three DATA_SIZE beats.
// Optional even-parity output enabled by STAGE_LEAF_UNPACK_PARITY_EN.
module stage_leaf_unpack #(
   parameter int NUM_NODES  = 4,
   parameter int DATA_SIZE  = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [3*DATA_SIZE-1:0]          inData,
   input  logic [$clog2(NUM_NODES)-1:0]    inNode,
   input  logic                            inValid,
   output logic                            inReady,
   output logic [DATA_SIZE-1:0]            outData,
   output logic [$clog2(NUM_NODES)-1:0]    outNode,
   output logic [1:0]                      outField,
   output logic                            outLast,
   output logic                            outValid,
   input  logic                            outReady,
`ifdef STAGE_LEAF_UNPACK_PARITY_EN
   output logic                            outParity,
`endif
   output logic [$clog2(FIFO_DEPTH):0]     count,
   output logic                            overflow
);

   localparam int NW = $clog2(NUM_NODES);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   logic [3*DATA_SIZE-1:0] data_mem_q [FIFO_DEPTH];
   logic [NW-1:0]          node_mem_q [FIFO_DEPTH];

   state_t          state_q, state_d;
   logic [1:0]      fc_q, fc_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;

   logic                   valid_s, beat_s, pop_s, push_s;
   logic [3*DATA_SIZE-1:0] head_s;
   logic [DATA_SIZE-1:0]   field_s;

   assign valid_s = (state_q == EMIT);
   assign beat_s  = valid_s & outReady;
   assign pop_s   = beat_s & (fc_q == 2'd2);
   // A full FIFO still accepts when the head record leaves in the same cycle.
   assign push_s  = inValid & ((count_q < DEPTH_C) | pop_s);
   assign head_s  = data_mem_q[rd_ptr_q];

   // Next-state logic for pointers, occupancy, field counter and overflow flag.
   always_comb begin
      wr_ptr_d   = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (inValid & ~push_s);
      fc_d       = fc_q;
      if (push_s && !pop_s) begin
         count_d = count_q + CW'(1);
      end else if (pop_s && !push_s) begin
         count_d = count_q - CW'(1);
      end else begin
         count_d = count_q;
      end
      if (pop_s) begin
         fc_d = 2'd0;
      end else if (beat_s) begin
         fc_d = fc_q + 2'd1;
      end else begin
         fc_d = fc_q;
      end
      state_d = (count_d != '0) ? EMIT : IDLE;
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fc_q       <= 2'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fc_q       <= fc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Record storage; contents are don't-care once the pointers are reset.
   always_ff @(posedge clk) begin
      if (!rst && push_s) begin
         data_mem_q[wr_ptr_q] <= inData;
         node_mem_q[wr_ptr_q] <= inNode;
      end
   end

   // Field slice of the head record selected by the field counter.
   always_comb begin
      case (fc_q)
         2'd0:    field_s = head_s[DATA_SIZE-1:0];
         2'd1:    field_s = head_s[2*DATA_SIZE-1:DATA_SIZE];
         default: field_s = head_s[3*DATA_SIZE-1:2*DATA_SIZE];
      endcase
   end

   // Beat outputs are forced to zero while no beat is offered.
   always_comb begin
      if (valid_s) begin
         outData  = field_s;
         outNode  = node_mem_q[rd_ptr_q];
         outField = fc_q;
         outLast  = (fc_q == 2'd2);
      end else begin
         outData  = '0;
         outNode  = '0;
         outField = 2'd0;
         outLast  = 1'b0;
      end
   end

   assign outValid = valid_s;
   assign inReady  = (count_q < DEPTH_C);
   assign count    = count_q;
   assign overflow = overflow_q;

`ifdef STAGE_LEAF_UNPACK_PARITY_EN
   function automatic logic parity_f(input logic [NW+2+DATA_SIZE-1:0] v);
      return ^v;
   endfunction

   assign outParity = parity_f({outNode, outField, outData});
`endif

endmodule
